// File: rtl/neg_share_arbiter.sv
// Round-robin arbiter sharing one registered two's-complement negation stage
// among NUM_REQ requesters; results leave on one valid/ready port tagged with the id.
module neg_share_arbiter #(
    parameter int N       = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*N-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_neg,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic [N-1:0]         out_data,
    output logic [ID_W-1:0]      out_id,
    output logic                 out_ovf,
    input  logic                 out_ready,
    output logic [15:0]          grant_cnt
);

    localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    logic              out_valid_reg;
    logic [N-1:0]      out_data_reg;
    logic [ID_W-1:0]   out_id_reg;
    logic              out_ovf_reg;
    logic [15:0]       grant_cnt_reg;
    logic [ID_W-1:0]   rr_ptr_reg;

    logic              acc_en;
    logic              grant_exists;
    logic              accept;
    logic [ID_W-1:0]   gnt;
    logic [ID_W-1:0]   rr_ptr_next;
    logic [N-1:0]      op_sel;
    logic              neg_sel;
    logic [N-1:0]      result_next;
    logic              ovf_next;

    assign acc_en = ~out_valid_reg | out_ready;
    assign accept = acc_en & grant_exists;

    // Scan from the far end back toward rr_ptr so the last hit wins, which is
    // the first valid requester in rotation order starting at rr_ptr.
    always_comb begin
        gnt          = '0;
        grant_exists = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                gnt          = ID_W'(idx);
                grant_exists = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept & (gnt == ID_W'(gi));
        end
    endgenerate

    assign op_sel      = req_data[gnt*N +: N];
    assign neg_sel     = req_neg[gnt];
    assign result_next = neg_sel ? (~op_sel + ONE) : op_sel;
    // Negating the most negative value wraps back onto itself; flag it instead of saturating.
    assign ovf_next    = neg_sel & (op_sel == MOST_NEG);
    assign rr_ptr_next = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_id_reg    <= '0;
            out_ovf_reg   <= 1'b0;
            grant_cnt_reg <= '0;
            rr_ptr_reg    <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= result_next;
            out_id_reg    <= gnt;
            out_ovf_reg   <= ovf_next;
            grant_cnt_reg <= grant_cnt_reg + 16'd1;
            rr_ptr_reg    <= rr_ptr_next;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_id    = out_id_reg;
    assign out_ovf   = out_ovf_reg;
    assign grant_cnt = grant_cnt_reg;

endmodule

// File: tb/tb_neg_share_arbiter.sv
// Bench for neg_share_arbiter: scenario tasks with directed checks plus a
// scoreboard monitor that predicts grants and results from its own model.
module tb_neg_share_arbiter;

    localparam int N       = 16;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*N-1:0] req_data;
    logic [NUM_REQ-1:0]   req_neg;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic [N-1:0]         out_data;
    logic [ID_W-1:0]      out_id;
    logic                 out_ovf;
    logic                 out_ready;
    logic [15:0]          grant_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    neg_share_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_neg   (req_neg),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ovf   (out_ovf),
        .out_ready (out_ready),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected {data, id, ovf}, pushed on predicted acceptance.
    typedef struct packed {
        logic [N-1:0]    data;
        logic [ID_W-1:0] id;
        logic            ovf;
    } result_t;

    result_t sb[$];
    logic    m_valid = 1'b0;
    int      m_rr    = 0;
    int      m_cnt   = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_rr    = 0;
            m_cnt   = 0;
            sb.delete();
        end else begin
            logic             acc;
            logic             found;
            int               g;
            logic [NUM_REQ-1:0] exp_ready;
            logic [N-1:0]     op;
            result_t          e;
            acc   = !m_valid || out_ready;
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (m_rr + k) % NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
            exp_ready = (acc && found) ? NUM_REQ'(1 << g) : '0;

            n_checks++;
            if (out_valid !== m_valid) begin
                n_fail++;
                $display("FAIL sb_out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
            end
            n_checks++;
            if (grant_cnt !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL sb_grant_cnt: got %0d expected %0d at %0t", grant_cnt, m_cnt, $time);
            end
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL sb_req_ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
            end
            if (m_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: got data=%h id=%0d with no expected entry at %0t", out_data, out_id, $time);
                end else begin
                    e = sb[0];
                    if ({out_data, out_id, out_ovf} !== e) begin
                        n_fail++;
                        $display("FAIL sb_result: got data=%h id=%0d ovf=%b expected data=%h id=%0d ovf=%b at %0t",
                                 out_data, out_id, out_ovf, e.data, e.id, e.ovf, $time);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (acc && found) begin
                op     = req_data[g*N +: N];
                e.data = req_neg[g] ? (16'h0000 - op) : op;
                e.id   = ID_W'(g);
                e.ovf  = req_neg[g] && (op == 16'h8000);
                sb.push_back(e);
                m_rr    = (g + 1) % NUM_REQ;
                m_cnt   = (m_cnt + 1) % 65536;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic issue(input int lane, input logic [N-1:0] d, input logic neg);
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[lane] = 1'b1;
        req_data[lane*N +: N] = d;
        req_neg[lane] = neg;
        @(negedge clk);
    endtask

    task automatic drop_req();
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; req_neg = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || req_ready !== 4'b0000 || grant_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_idle: got valid=%b ready=%b cnt=%0d expected 0/0000/0", out_valid, req_ready, grant_cnt);
            end
        end
        n_checks++;
        if (out_data !== 16'h0000 || out_id !== 2'd0 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fields: got data=%h id=%0d ovf=%b expected 0000/0/0", out_data, out_id, out_ovf);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_negate();
        issue(2, 16'h0005, 1'b1);
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL neg5_ready: got %b expected 0100", req_ready);
        end
        drop_req();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hFFFB || out_id !== 2'd2 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL neg5_result: got v=%b data=%h id=%0d ovf=%b expected 1/fffb/2/0", out_valid, out_data, out_id, out_ovf);
        end
        issue(2, 16'h0000, 1'b1);
        drop_req();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_id !== 2'd2 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL neg0_result: got v=%b data=%h id=%0d ovf=%b expected 1/0000/2/0", out_valid, out_data, out_id, out_ovf);
        end
        $display("test_single_negate done");
    endtask

    task automatic test_overflow();
        issue(0, 16'h8000, 1'b1);
        drop_req();
        n_checks++;
        if (out_data !== 16'h8000 || out_id !== 2'd0 || out_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_neg: got data=%h id=%0d ovf=%b expected 8000/0/1", out_data, out_id, out_ovf);
        end
        issue(1, 16'h8000, 1'b0);
        drop_req();
        n_checks++;
        if (out_data !== 16'h8000 || out_id !== 2'd1 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pass: got data=%h id=%0d ovf=%b expected 8000/1/0", out_data, out_id, out_ovf);
        end
        $display("test_overflow done");
    endtask

    task automatic load_all_lanes();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*N +: N] = 16'h1230 + 16'(i * 16'h0101);
            req_neg[i] = i[0];
        end
        req_valid = '1;
    endtask

    task automatic test_round_robin();
        do_reset();
        @(posedge clk); #1;
        load_all_lanes();
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_id !== 2'(k % NUM_REQ)) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: got v=%b id=%0d expected 1/%0d", k, out_valid, out_id, k % NUM_REQ);
            end
        end
        n_checks++;
        if (grant_cnt !== 16'd8) begin
            n_fail++;
            $display("FAIL rr_count: got %0d expected 8", grant_cnt);
        end
        drop_req();
        repeat (2) @(negedge clk);
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure();
        logic [N-1:0] held;
        do_reset();
        @(posedge clk); #1;
        out_ready = 1'b0;
        load_all_lanes();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_first_ready: got %b expected 0001", req_ready);
        end
        held = 16'h1230;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== held || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got v=%b id=%0d data=%h ready=%b expected 1/0/%h/0000",
                         c, out_valid, out_id, out_data, req_ready, held);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_id !== 2'd0 || req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_release: got id=%0d ready=%b expected 0/0010", out_id, req_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_id !== 2'(k % NUM_REQ)) begin
                n_fail++;
                $display("FAIL bp_seq[%0d]: got v=%b id=%0d expected 1/%0d", k, out_valid, out_id, k % NUM_REQ);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("test_backpressure done");
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got out_valid=%b expected 1", out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'b1010;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || grant_cnt !== 16'd0 || req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b cnt=%0d ready=%b expected 0/0/0010", out_valid, grant_cnt, req_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_first_grant: got v=%b id=%0d expected 1/1", out_valid, out_id);
        end
        repeat (2) @(negedge clk);
        $display("test_reset_midstream done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_negate();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neg_share_arbiter.md
Name: neg_share_arbiter

Overview:
- Round-robin arbiter that shares one registered two's-complement negation stage among NUM_REQ requesters, e.g. synapse lanes that must apply inhibitory (negated) weights before accumulation into membrane potential.
- Each requester presents an N-bit operand and a negate flag over a valid/ready handshake.
- The block grants one requester per cycle, computes the operand or its negation, and emits the result tagged with the requester id on a single valid/ready output port with backpressure.

Parameters:
- N, 16, operand/result width in bits (two's complement).
- NUM_REQ, 4, number of requesters (≥2).
- ID_W, 2, width of requester id; must satisfy 2^ID_W ≥ NUM_REQ.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i: requester i has an operand.
- req_data  input  NUM_REQ*N  operand of requester i at bits [i*N +: N].
- req_neg  input  NUM_REQ  bit i: 1 = negate operand, 0 = pass through.
- req_ready  output  NUM_REQ  bit i: requester i's operand is accepted this cycle (one-hot or zero).
- out_valid  output  1  result register holds a valid result.
- out_data  output  N  result.
- out_id  output  ID_W  index of the requester that produced out_data.
- out_ovf  output  1  negation overflow (negated operand was the most negative value).
- out_ready  input  1  downstream accepts the result.
- grant_cnt  output  16  total accepted transactions, wraps at 2^16.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_id=0, out_ovf=0, grant_cnt=0, round-robin pointer rr_ptr=0.
  - Takes precedence over any in-flight transfer; the pending result is discarded.
- Accept enable (combinational): acc_en = ~out_valid | out_ready.
- Grant (combinational):
  - gnt = first index i scanning rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ, with req_valid[i]=1.
  - No grant if no req_valid bit is set.
- req_ready[i] = acc_en & grant_exists & (gnt==i). It must not depend on req_data or req_neg.
- On acceptance (acc_en & grant_exists) at a clock edge:
  - out_data <= req_neg[gnt] ? (~op + 1) mod 2^N : op, where op = the operand of requester gnt.
  - out_ovf <= req_neg[gnt] & (op == 1 followed by N-1 zeros). The result then equals op, i.e. wraps; it is not saturated.
  - out_id <= gnt; out_valid <= 1.
  - rr_ptr <= (gnt+1) mod NUM_REQ; grant_cnt <= grant_cnt+1.
- When out_valid & out_ready and there is no acceptance: out_valid <= 0. out_data, out_id and out_ovf hold their last values.
- Stall (out_valid & ~out_ready): all output fields are held stable, all req_ready=0, and rr_ptr is frozen.
- Latency and throughput: result appears the cycle after acceptance; one result per cycle is sustained while out_ready=1.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
- Negating 0 gives 0 with out_ovf=0.
- rr_ptr advances only on acceptance, never on idle cycles.
- Requesters must hold req_valid, req_data and req_neg stable until req_ready. The block does not check this.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all req_valid=0 → out_valid=0, req_ready=0, grant_cnt=0 for 5 cycles.
- Single negate, N=16: req 2 sends 0x0005 with neg=1, out_ready=1 → req_ready=4'b0100 in cycle 0; cycle 1: out_valid=1, out_data=0xFFFB, out_id=2, out_ovf=0. Also 0x0000 with neg=1 → 0x0000, ovf=0.
- Overflow: req 0 sends 0x8000 with neg=1 → out_data=0x8000, out_ovf=1. req 1 sends 0x8000 with neg=0 → out_data=0x8000, out_ovf=0.
- Round-robin: all 4 requesters valid continuously, out_ready=1 → out_id sequence 0,1,2,3,0,1,… one result per cycle; grant_cnt=8 after 8 results.
- Backpressure: all valid, out_ready=0 for 3 cycles after the first result → out_valid=1 with identical out_data/out_id held, req_ready=0. After release, ids continue in order with no duplicate or skipped transaction.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, grant_cnt=0. The first grant after release goes to the lowest valid index.
